// File: rtl/iaram_stream_writer_if.sv
// Interface bundle for the IARAM stream writer: it carries the DRAM beat inputs,
// the PE read port and the status outputs.
interface iaram_stream_writer_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4,
  parameter int MAX_CH    = 3,
  parameter int DEPTH     = 64
) ();
  localparam int CH_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic                        clear;
  logic [NUM_LANES-1:0]        act_valid;
  logic [NUM_LANES*DATA_W-1:0] act_data;
  logic [CH_W-1:0]             act_ch;
  logic [NUM_LANES-1:0]        idx_valid;
  logic [NUM_LANES*IDX_W-1:0]  idx_data;
  logic [CH_W-1:0]             idx_ch;
  logic                        stream_done;
  logic                        rd_en;
  logic [CH_W-1:0]             rd_ch;
  logic [AW-1:0]               rd_addr;
  logic                        rd_valid;
  logic [DATA_W-1:0]           rd_data;
  logic [IDX_W-1:0]            rd_idx;
  logic [MAX_CH*PTR_W-1:0]     ch_count;
  logic                        loaded;
  logic                        overflow;
  logic                        mismatch;

  modport master (
    output clear, act_valid, act_data, act_ch, idx_valid, idx_data, idx_ch,
           stream_done, rd_en, rd_ch, rd_addr,
    input  rd_valid, rd_data, rd_idx, ch_count, loaded, overflow, mismatch
  );

  modport slave (
    input  clear, act_valid, act_data, act_ch, idx_valid, idx_data, idx_ch,
           stream_done, rd_en, rd_ch, rd_addr,
    output rd_valid, rd_data, rd_idx, ch_count, loaded, overflow, mismatch
  );
endinterface

// File: rtl/iaram_stream_writer.sv
// Packs lane-sparse activation and index beats densely into per-channel IARAM banks.
// It tracks the entry count of each channel and serves the PE through a 1-cycle read port.
module iaram_stream_writer #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4,
  parameter int MAX_CH    = 3,
  parameter int DEPTH     = 64
) (
  input logic                  clk,
  input logic                  rst,
  iaram_stream_writer_if.slave bus
);
  localparam int CH_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int SUM_W = PTR_W + $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {EMPTY, FILL_DATA, FILL_IDX, LOADED} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     data_ptr [MAX_CH];
  logic [PTR_W-1:0]     idx_ptr  [MAX_CH];
  logic [CH_W-1:0]      cur_ch;
  logic [DATA_W-1:0]    data_mem [MAX_CH][DEPTH];
  logic [IDX_W-1:0]     idx_mem  [MAX_CH][DEPTH];

  logic                 act_any, idx_any, accept, act_ch_ok, idx_ch_ok, rd_ch_ok, rd_hit;
  logic                 act_adv, idx_adv, act_drop, idx_drop, new_ch, close_bad;
  logic [PTR_W-1:0]     act_base, idx_base, act_ptr_nxt, idx_ptr_nxt;
  logic [SUM_W-1:0]     act_sum, idx_sum;
  logic [SUM_W-1:0]     act_addr [NUM_LANES];
  logic [SUM_W-1:0]     idx_addr [NUM_LANES];
  logic [NUM_LANES-1:0] act_we, idx_we;
  logic                 loaded_nxt, overflow_set, mismatch_set;
  logic                 loaded, overflow, mismatch, rd_valid;
  logic [DATA_W-1:0]    rd_data;
  logic [IDX_W-1:0]     rd_idx;

  function automatic logic [SUM_W-1:0] lanes_below(input logic [NUM_LANES-1:0] mask,
                                                   input int lane);
    lanes_below = '0;
    for (int j = 0; j < NUM_LANES; j++)
      if (j < lane && mask[j]) lanes_below += SUM_W'(1);
  endfunction

  // Lane address generation and drop detection for both streams.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    act_any   = |bus.act_valid;
    idx_any   = |bus.idx_valid;
    accept    = !bus.clear && (state != LOADED);
    act_ch_ok = int'(bus.act_ch) < MAX_CH;
    idx_ch_ok = int'(bus.idx_ch) < MAX_CH;
    act_base  = act_ch_ok ? data_ptr[bus.act_ch] : '0;
    idx_base  = idx_ch_ok ? idx_ptr[bus.idx_ch] : '0;
    act_we    = '0;
    idx_we    = '0;
    act_drop  = 1'b0;
    idx_drop  = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      act_addr[i] = SUM_W'(act_base) + lanes_below(bus.act_valid, i);
      idx_addr[i] = SUM_W'(idx_base) + lanes_below(bus.idx_valid, i);
      if (bus.act_valid[i]) begin
        if (accept && act_ch_ok && act_addr[i] < SUM_W'(DEPTH)) act_we[i] = 1'b1;
        else if (!bus.clear)                                    act_drop  = 1'b1;
      end
      if (bus.idx_valid[i]) begin
        if (accept && idx_ch_ok && idx_addr[i] < SUM_W'(DEPTH)) idx_we[i] = 1'b1;
        else if (!bus.clear)                                    idx_drop  = 1'b1;
      end
    end
    act_sum     = SUM_W'(act_base) + SUM_W'($countones(bus.act_valid));
    idx_sum     = SUM_W'(idx_base) + SUM_W'($countones(bus.idx_valid));
    act_ptr_nxt = (act_sum > SUM_W'(DEPTH)) ? PTR_W'(DEPTH) : act_sum[PTR_W-1:0];
    idx_ptr_nxt = (idx_sum > SUM_W'(DEPTH)) ? PTR_W'(DEPTH) : idx_sum[PTR_W-1:0];
    act_adv     = accept && act_ch_ok && act_any;
    idx_adv     = accept && idx_ch_ok && idx_any;
    new_ch      = act_any && (bus.act_ch != cur_ch);
    close_bad   = (int'(cur_ch) < MAX_CH) && (idx_ptr[cur_ch] != data_ptr[cur_ch]);
    rd_ch_ok    = int'(bus.rd_ch) < MAX_CH;
    rd_hit      = rd_ch_ok && (PTR_W'(bus.rd_addr) < data_ptr[bus.rd_ch]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) state_nxt = EMPTY;
    else begin
      unique case (state)
        EMPTY:     if (act_any) state_nxt = FILL_DATA;
        FILL_DATA: if (idx_any) state_nxt = FILL_IDX;
        FILL_IDX:  if (bus.stream_done)     state_nxt = LOADED;
                   else if (new_ch)         state_nxt = FILL_DATA;
        LOADED:    state_nxt = LOADED;
        default:   state_nxt = EMPTY;
      endcase
    end
  end

  // Closing a channel compares its index count against its data count.
  always_comb begin
    loaded_nxt   = (state_nxt == LOADED);
    overflow_set = act_drop || idx_drop;
    mismatch_set = !bus.clear && (state == FILL_IDX) && close_bad &&
                   (bus.stream_done || new_ch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < MAX_CH; c++) begin
        data_ptr[c] <= '0;
        idx_ptr[c]  <= '0;
      end
      cur_ch   <= '0;
      loaded   <= 1'b0;
      overflow <= 1'b0;
      mismatch <= 1'b0;
    end else if (bus.clear) begin
      for (int c = 0; c < MAX_CH; c++) begin
        data_ptr[c] <= '0;
        idx_ptr[c]  <= '0;
      end
      cur_ch   <= '0;
      loaded   <= 1'b0;
      overflow <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (act_adv) begin
        data_ptr[bus.act_ch] <= act_ptr_nxt;
        cur_ch               <= bus.act_ch;
      end
      if (idx_adv) idx_ptr[bus.idx_ch] <= idx_ptr_nxt;
      loaded   <= loaded_nxt;
      overflow <= overflow | overflow_set;
      mismatch <= mismatch | mismatch_set;
    end
  end

  // NOTE: banks have no reset; entries at or above ch_count are never returned to the PE.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (act_we[i]) data_mem[bus.act_ch][act_addr[i][AW-1:0]] <= bus.act_data[i*DATA_W +: DATA_W];
      if (idx_we[i]) idx_mem[bus.idx_ch][idx_addr[i][AW-1:0]]  <= bus.idx_data[i*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_idx   <= '0;
    end else begin
      rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data <= rd_hit ? data_mem[bus.rd_ch][bus.rd_addr] : '0;
        rd_idx  <= rd_hit ? idx_mem[bus.rd_ch][bus.rd_addr]  : '0;
      end
    end
  end

  always_comb begin
    bus.ch_count = '0;
    for (int c = 0; c < MAX_CH; c++) bus.ch_count[c*PTR_W +: PTR_W] = data_ptr[c];
  end

  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.rd_idx   = rd_idx;
  assign bus.loaded   = loaded;
  assign bus.overflow = overflow;
  assign bus.mismatch = mismatch;
endmodule

// File: tb/tb_iaram_stream_writer.sv
// Directed bench for iaram_stream_writer. Every expected value in it is worked out
// by hand from the packing, counting and flag rules.
module tb_iaram_stream_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iaram_stream_writer_if #(.NUM_LANES(4), .DATA_W(16), .IDX_W(4), .MAX_CH(3), .DEPTH(64)) bus ();

  iaram_stream_writer #(.NUM_LANES(4), .DATA_W(16), .IDX_W(4), .MAX_CH(3), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] cnt(input int c);
    return bus.ch_count[c*7 +: 7];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic act_beat(input logic [1:0] ch, input logic [3:0] mask,
                          input logic [15:0] d0, d1, d2, d3);
    bus.act_ch = ch; bus.act_valid = mask; bus.act_data = {d3, d2, d1, d0};
    step();
    bus.act_valid = '0;
  endtask

  task automatic idx_beat(input logic [1:0] ch, input logic [3:0] mask,
                          input logic [3:0] i0, i1, i2, i3);
    bus.idx_ch = ch; bus.idx_valid = mask; bus.idx_data = {i3, i2, i1, i0};
    step();
    bus.idx_valid = '0;
  endtask

  task automatic read_chk(input logic [1:0] ch, input logic [5:0] addr,
                          input logic [15:0] exp_d, input logic [3:0] exp_i);
    bus.rd_en = 1'b1; bus.rd_ch = ch; bus.rd_addr = addr;
    step();
    bus.rd_en = 1'b0;
    check($sformatf("rd_valid ch%0d a%0d", ch, addr), 64'(bus.rd_valid), 64'(1));
    check($sformatf("rd_data ch%0d a%0d", ch, addr), 64'(bus.rd_data), 64'(exp_d));
    check($sformatf("rd_idx ch%0d a%0d", ch, addr), 64'(bus.rd_idx), 64'(exp_i));
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.clear = 0; bus.act_valid = '0; bus.act_data = '0; bus.act_ch = '0;
    bus.idx_valid = '0; bus.idx_data = '0; bus.idx_ch = '0; bus.stream_done = 0;
    bus.rd_en = 0; bus.rd_ch = '0; bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_valid", 64'(bus.rd_valid), 64'(0));
    check("reset ch_count", 64'(bus.ch_count), 64'(0));
    check("reset flags", 64'({bus.loaded, bus.overflow, bus.mismatch}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Dense and partial beats on channel 0.
    act_beat(2'd0, 4'b1111, 16'd1, 16'd2, 16'd3, 16'd4);
    act_beat(2'd0, 4'b0011, 16'd5, 16'd6, 16'd0, 16'd0);
    idx_beat(2'd0, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4);
    idx_beat(2'd0, 4'b0011, 4'd5, 4'd6, 4'd0, 4'd0);
    check("ch_count0 after t1", 64'(cnt(0)), 64'(6));
    for (int a = 0; a < 6; a++) read_chk(2'd0, 6'(a), 16'(a + 1), 4'(a + 1));
    read_chk(2'd0, 6'd6, 16'd0, 4'd0);
    step();
    check("rd_valid drops", 64'(bus.rd_valid), 64'(0));

    // A sparse mask packs densely into channel 1.
    act_beat(2'd1, 4'b1010, 16'd0, 16'd7, 16'd0, 16'd9);
    check("ch_count1 sparse", 64'(cnt(1)), 64'(2));
    idx_beat(2'd1, 4'b0011, 4'd2, 4'd3, 4'd0, 4'd0);
    read_chk(2'd1, 6'd0, 16'd7, 4'd2);
    read_chk(2'd1, 6'd1, 16'd9, 4'd3);

    // Channel 2 completes the layer, then stream_done loads it.
    act_beat(2'd2, 4'b0111, 16'd10, 16'd11, 16'd12, 16'd0);
    idx_beat(2'd2, 4'b0111, 4'd1, 4'd1, 4'd1, 4'd0);
    bus.stream_done = 1'b1;
    check("loaded before edge", 64'(bus.loaded), 64'(0));
    step();
    bus.stream_done = 1'b0;
    check("loaded after done", 64'(bus.loaded), 64'(1));
    check("mismatch clean", 64'(bus.mismatch), 64'(0));
    check("overflow clean", 64'(bus.overflow), 64'(0));
    check("ch_count2", 64'(cnt(2)), 64'(3));
    act_beat(2'd0, 4'b0001, 16'd99, 16'd0, 16'd0, 16'd0);
    check("overflow in loaded", 64'(bus.overflow), 64'(1));
    check("ch_count0 held in loaded", 64'(cnt(0)), 64'(6));
    pulse_clear();
    check("clear ch_count", 64'(bus.ch_count), 64'(0));
    check("clear flags", 64'({bus.loaded, bus.overflow, bus.mismatch}), 64'(0));

    // Five data entries against four indices on channel 2.
    act_beat(2'd2, 4'b1111, 16'd1, 16'd2, 16'd3, 16'd4);
    act_beat(2'd2, 4'b0001, 16'd5, 16'd0, 16'd0, 16'd0);
    idx_beat(2'd2, 4'b1111, 4'd1, 4'd1, 4'd1, 4'd1);
    bus.stream_done = 1'b1;
    step();
    bus.stream_done = 1'b0;
    check("mismatch set", 64'(bus.mismatch), 64'(1));
    check("loaded with mismatch", 64'(bus.loaded), 64'(1));
    repeat (3) step();
    check("mismatch sticky", 64'(bus.mismatch), 64'(1));
    pulse_clear();
    check("mismatch cleared", 64'(bus.mismatch), 64'(0));

    // 68 values into a 64-entry bank.
    for (int b = 0; b < 16; b++)
      act_beat(2'd0, 4'b1111, 16'(b*4 + 1), 16'(b*4 + 2), 16'(b*4 + 3), 16'(b*4 + 4));
    check("ch_count0 full", 64'(cnt(0)), 64'(64));
    check("no overflow at exact fill", 64'(bus.overflow), 64'(0));
    act_beat(2'd0, 4'b1111, 16'd100, 16'd101, 16'd102, 16'd103);
    check("ch_count0 saturated", 64'(cnt(0)), 64'(64));
    check("overflow on full", 64'(bus.overflow), 64'(1));
    bus.rd_en = 1'b1; bus.rd_ch = 2'd0; bus.rd_addr = 6'd63;
    step();
    bus.rd_en = 1'b0;
    check("last entry kept", 64'(bus.rd_data), 64'(64));
    pulse_clear();

    // Asynchronous reset in the middle of a fill.
    bus.act_ch = 2'd1; bus.act_valid = 4'b1111; bus.act_data = {16'd24, 16'd23, 16'd22, 16'd21};
    bus.idx_ch = 2'd3; bus.idx_valid = 4'b0001; bus.idx_data = '0;
    bus.rd_en = 1'b1; bus.rd_ch = 2'd0; bus.rd_addr = 6'd0;
    step();
    bus.act_valid = '0; bus.idx_valid = '0; bus.rd_en = 1'b0;
    check("pre-rst ch_count1", 64'(cnt(1)), 64'(4));
    check("pre-rst overflow bad ch", 64'(bus.overflow), 64'(1));
    check("pre-rst rd_valid", 64'(bus.rd_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async rst ch_count", 64'(bus.ch_count), 64'(0));
    check("async rst outputs", 64'({bus.rd_valid, bus.loaded, bus.overflow, bus.mismatch}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.act_ch = 2'd1; bus.act_valid = 4'b0001; bus.act_data = 64'(16'd55);
    bus.idx_ch = 2'd1; bus.idx_valid = 4'b0001; bus.idx_data = 16'(4'd5);
    step();
    bus.act_valid = '0; bus.idx_valid = '0;
    check("restart ch_count1", 64'(cnt(1)), 64'(1));
    read_chk(2'd1, 6'd0, 16'd55, 4'd5);

    // A clear wins over a beat in the same cycle.
    bus.clear = 1'b1;
    bus.act_ch = 2'd0; bus.act_valid = 4'b1111; bus.act_data = {16'd4, 16'd3, 16'd2, 16'd1};
    step();
    bus.clear = 1'b0; bus.act_valid = '0;
    check("clear drops beat", 64'(bus.ch_count), 64'(0));
    check("clear no overflow", 64'(bus.overflow), 64'(0));
    read_chk(2'd0, 6'd0, 16'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iaram_stream_writer.md
Name: iaram_stream_writer

Overview:
- Sits directly downstream of the DRAM streaming stage.
- Consumes compressed-activation beats (up to NUM_LANES values per cycle) and the matching index beats, per input channel.
- Packs them into per-channel IARAM banks and tracks per-channel entry counts.
- Exposes a 1-cycle-latency read port to the PE and reports when the full input volume is resident.

Parameters:
NUM_LANES, 4, values per DRAM beat (equals the DRAM-streaming lane count)
DATA_W, 16, activation value width (signed)
IDX_W, 4, zero-run index width
MAX_CH, 3, number of input channels buffered
DEPTH, 64, entries per channel bank (power of two)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous start-of-layer clear
act_valid  in  NUM_LANES  per-lane valid, activation beat
act_data  in  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
act_ch  in  clog2(MAX_CH)  channel of activation beat
idx_valid  in  NUM_LANES  per-lane valid, index beat
idx_data  in  NUM_LANES*IDX_W  lane-packed indices
idx_ch  in  clog2(MAX_CH)  channel of index beat
stream_done  in  1  one-cycle pulse: last channel streamed
rd_en  in  1  PE read request
rd_ch  in  clog2(MAX_CH)  read channel
rd_addr  in  clog2(DEPTH)  read entry
rd_valid  out  1  read data valid
rd_data  out  DATA_W  activation at (rd_ch, rd_addr)
rd_idx  out  IDX_W  index at (rd_ch, rd_addr)
ch_count  out  MAX_CH*(clog2(DEPTH)+1)  committed entries per channel
loaded  out  1  whole input resident
overflow  out  1  sticky: beat lane dropped (bank full)
mismatch  out  1  sticky: index count differs from data count on channel close

Behaviour:
- Reset (async, rst=1): all write pointers 0; state EMPTY; rd_valid, rd_data, rd_idx, loaded, overflow, mismatch, ch_count all 0. Bank contents are not reset.
- FSM states: EMPTY, FILL_DATA, FILL_IDX, LOADED.
- EMPTY→FILL_DATA: first cycle with any act_valid bit set.
- FILL_DATA→FILL_IDX: first idx_valid beat.
- FILL_IDX→FILL_DATA: act_valid on a new channel. On this transition, mismatch is set if idx_ptr[prev ch] != data_ptr[prev ch].
- FILL_IDX→LOADED: stream_done. The same mismatch check is applied to the current channel.
- LOADED: holds; loaded=1 registered (asserts the cycle after stream_done).
- clear from any state: →EMPTY, pointers/flags/loaded zeroed. clear wins over a same-cycle beat; that beat is dropped.
- Lane packing:
  - Lanes are packed densely in lane order, so a sparse valid mask such as 1010 writes 2 consecutive entries.
  - Write address for lane i = ptr[ch] + popcount(valid[i-1:0]).
  - ptr[ch] += popcount(valid).
  - Data and index streams use independent pointers; both may be valid in the same cycle, on different or the same channel.
- Full/overflow:
  - Any lane whose address would be ≥DEPTH is dropped; the pointer saturates at DEPTH; overflow sets and stays set until clear or reset.
  - Writes to a channel ≥MAX_CH are dropped and set overflow.
- ch_count[c] = data_ptr[c], updated the cycle after the write; width clog2(DEPTH)+1 so DEPTH is representable.
- Read:
  - rd_en at cycle N → rd_valid, rd_data, rd_idx at N+1.
  - If rd_addr ≥ ch_count[rd_ch], rd_data=0 and rd_idx=0 with rd_valid still 1.
  - Reads are permitted in any state.
  - A same-cycle write to the read address returns the old value (read-before-write).
- Beats in LOADED (without clear) are dropped and set overflow.
- Reset mid-fill: everything returns to reset values immediately; a partial layer is discarded.

Test Plan:
1. Reset, then ch0 act beats 1111 (1,2,3,4), then 0011 (5,6); idx beats 1111, 0011 → ch_count[0]=6; reading addr 0..5 returns 1..6 one cycle after rd_en; reading addr 6 returns 0 with rd_valid=1.
2. Sparse mask act_valid=1010 (lane1=7, lane3=9) into empty ch1 → entries 0=7, 1=9; ch_count[1]=2.
3. Three channels streamed (data then idx each), stream_done pulse → loaded=1 exactly one cycle later; mismatch=0; overflow=0.
4. ch2: 5 data entries but 4 index entries, then stream_done → mismatch=1, loaded=1; mismatch clears only on clear.
5. 17 beats of 1111 into ch0 (DEPTH=64) → first 64 written, 4 dropped; ch_count[0]=64; overflow=1.
6. Assert rst asynchronously mid-FILL_DATA (between clock edges) → all outputs 0 immediately; the next beat restarts at addr 0. clear coincident with a beat → beat dropped, ch_count=0.
